// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN result packer.
// Optional feature macro used by the packer: BNN_PACK_STATS_EN.
package bnn_pkg;

  localparam int HALF_W = 32;
  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } pack_state_t;

  // Number of set bits in a packed output-channel word.
  function automatic logic [6:0] popcount64(input logic [WORD_W-1:0] w);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < WORD_W; i++) begin
      n = n + {6'd0, w[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/bnn_sync_fifo.sv
// Show-ahead synchronous FIFO. A push while full is only taken when a pop
// happens in the same cycle; a pop while empty is ignored.
module bnn_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);
  assign dout      = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; memory is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bnn_result_packer.sv
// Pairs 32-bit BNN result halves into 64-bit words, buffers them and streams
// them to the feature-map writer with auto-incrementing addresses.
// Optional build macro BNN_PACK_STATS_EN adds a saturating ones_count output.
module bnn_result_packer
  import bnn_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              store_in,
  input  logic              half_sel,
  input  logic [HALF_W-1:0] bins_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef BNN_PACK_STATS_EN
  ,
  output logic [15:0]       ones_count
`endif
);

  pack_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] push_cnt_q, push_cnt_d;
  logic [ADDR_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic              lo_valid_q, lo_valid_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic fifo_full_s;
  logic fifo_empty_s;
  logic pop_s;
  logic store_lo_s;
  logic store_hi_s;
  logic push_req_s;
  logic overflow_s;

  assign pop_s      = ~fifo_empty_s & wr_ready;
  assign store_lo_s = (state_q == COLLECT) & store_in & ~half_sel;
  assign store_hi_s = (state_q == COLLECT) & store_in & half_sel;
  assign push_req_s = store_hi_s & lo_valid_q;
  assign overflow_s = push_req_s & fifo_full_s & ~pop_s;

  bnn_sync_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_req_s),
    .pop  (pop_s),
    .din  ({bins_in, lo_q}),
    .dout (wr_data),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  assign wr_valid = ~fifo_empty_s;
  assign wr_addr  = base_q + pop_cnt_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign err      = err_q;

  // Next-state logic: layer setup, half pairing, error tracking and drain/done.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_d      = num_q;
    push_cnt_d = push_cnt_q;
    pop_cnt_d  = pop_cnt_q + (pop_s ? ADDR_W'(1) : ADDR_W'(0));
    lo_d       = lo_q;
    lo_valid_d = lo_valid_q;
    err_d      = err_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (layer_start) begin
          base_d     = base_addr;
          num_d      = num_words;
          push_cnt_d = '0;
          pop_cnt_d  = '0;
          lo_valid_d = 1'b0;
          err_d      = 1'b0;
          state_d    = (num_words == '0) ? DRAIN : COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (store_lo_s) begin
          lo_d       = bins_in;
          lo_valid_d = 1'b1;
          err_d      = err_q | lo_valid_q;
        end else if (store_hi_s) begin
          if (lo_valid_q) begin
            lo_valid_d = 1'b0;
            push_cnt_d = push_cnt_q + ADDR_W'(1);
            err_d      = err_q | overflow_s;
            state_d    = (push_cnt_d == num_q) ? DRAIN : COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (fifo_empty_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      num_q      <= '0;
      push_cnt_q <= '0;
      pop_cnt_q  <= '0;
      lo_q       <= '0;
      lo_valid_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      push_cnt_q <= push_cnt_d;
      pop_cnt_q  <= pop_cnt_d;
      lo_q       <= lo_d;
      lo_valid_q <= lo_valid_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

`ifdef BNN_PACK_STATS_EN
  logic [15:0] ones_q, ones_d;
  logic [16:0] ones_sum_s;
  logic        push_taken_s;

  assign push_taken_s = push_req_s & (~fifo_full_s | pop_s);
  assign ones_sum_s   = {1'b0, ones_q} + {10'd0, popcount64({bins_in, lo_q})};
  assign ones_count   = ones_q;

  // Saturating popcount of accepted words; cleared when a layer is accepted.
  always_comb begin
    ones_d = ones_q;
    if ((state_q == IDLE) && layer_start) begin
      ones_d = 16'd0;
    end else if (push_taken_s) begin
      ones_d = ones_sum_s[16] ? 16'hFFFF : ones_sum_s[15:0];
    end else begin
      ones_d = ones_q;
    end
  end

  // Popcount accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= 16'd0;
    end else begin
      ones_q <= ones_d;
    end
  end
`endif

endmodule

// File: tb/tb_bnn_result_packer.sv
// Directed self-checking bench for bnn_result_packer.
module tb_bnn_result_packer;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              layer_start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic              store_in;
  logic              half_sel;
  logic [31:0]       bins_in;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;
`ifdef BNN_PACK_STATS_EN
  logic [15:0]       ones_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wq_addr [$];
  logic [63:0]       wq_data [$];

  always #5 clk = ~clk;

  bnn_result_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .layer_start(layer_start),
    .base_addr  (base_addr),
    .num_words  (num_words),
    .store_in   (store_in),
    .half_sel   (half_sel),
    .bins_in    (bins_in),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef BNN_PACK_STATS_EN
    ,
    .ones_count (ones_count)
`endif
  );

  // Record completed transfers and done pulses mid-cycle.
  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_layer(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    layer_start = 1'b1;
    base_addr   = b;
    num_words   = n;
    tick();
    layer_start = 1'b0;
  endtask

  task automatic send_half(input logic hs, input logic [31:0] d);
    store_in = 1'b1;
    half_sel = hs;
    bins_in  = d;
    tick();
    store_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] lo, input logic [31:0] hi);
    send_half(1'b0, lo);
    send_half(1'b1, hi);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check_val(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_write(input int idx, input logic [ADDR_W-1:0] a, input logic [63:0] d);
    if (wq_addr.size() > idx) begin
      check_val($sformatf("wr_addr[%0d]", idx), 64'(wq_addr[idx]), 64'(a));
      check_val($sformatf("wr_data[%0d]", idx), wq_data[idx], d);
    end else begin
      check_val($sformatf("write_missing[%0d]", idx), 64'(wq_addr.size()), 64'(idx + 1));
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b0; layer_start = 1'b0; base_addr = '0; num_words = '0;
    store_in = 1'b0; half_sel = 1'b0; bins_in = 32'd0; wr_ready = 1'b0;
    tick();

    // Reset state
    do_reset();
    check_val("rst_wr_valid", 64'(wr_valid), 64'd0);
    check_val("rst_wr_addr", 64'(wr_addr), 64'd0);
    check_val("rst_wr_data", wr_data, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);

    // Basic two-word layer
    clear_log();
    wr_ready = 1'b1;
    start_layer(12'h010, 12'd2);
    check_val("basic_busy", 64'(busy), 64'd1);
    send_word(32'hAAAA5555, 32'h0F0F0F0F);
    send_word(32'h00000001, 32'h00000002);
    wait_done("basic_done", 20);
    check_write(0, 12'h010, 64'h0F0F0F0FAAAA5555);
    check_write(1, 12'h011, 64'h0000000200000001);
    check_val("basic_nwr", 64'(wq_addr.size()), 64'd2);
    check_val("basic_idle", 64'(busy), 64'd0);
    check_val("basic_err", 64'(err), 64'd0);

    // Backpressure and overflow
    do_reset();
    clear_log();
    wr_ready = 1'b0;
    start_layer(12'h100, 12'd10);
    for (int i = 0; i < 10; i++) send_word(32'h10000000 + 32'(i), 32'h20000000 + 32'(i));
    check_val("ovf_err", 64'(err), 64'd1);
    check_val("ovf_busy", 64'(busy), 64'd1);
    check_val("ovf_valid", 64'(wr_valid), 64'd1);
    check_val("ovf_nwr_held", 64'(wq_addr.size()), 64'd0);
    check_val("ovf_head_addr", 64'(wr_addr), 64'h100);
    wr_ready = 1'b1;
    wait_done("ovf_done", 40);
    check_val("ovf_nwr", 64'(wq_addr.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check_write(i, 12'h100 + 12'(i), {32'h20000000 + 32'(i), 32'h10000000 + 32'(i)});

    // Protocol errors
    do_reset();
    clear_log();
    wr_ready = 1'b1;
    start_layer(12'h020, 12'd1);
    send_half(1'b1, 32'h00000005);
    check_val("proto_lone_hi_err", 64'(err), 64'd1);
    check_val("proto_lone_hi_busy", 64'(busy), 64'd1);
    tick();
    check_val("proto_lone_hi_nwr", 64'(wq_addr.size()), 64'd0);
    send_half(1'b0, 32'h00000011);
    send_half(1'b0, 32'h00000022);
    send_half(1'b1, 32'h00000033);
    wait_done("proto_done", 20);
    check_val("proto_nwr", 64'(wq_addr.size()), 64'd1);
    check_write(0, 12'h020, 64'h0000003300000022);
    check_val("proto_err_sticky", 64'(err), 64'd1);

    // Zero-length layer: done two cycles after start, err cleared by start
    clear_log();
    d0 = done_cnt;
    start_layer(12'h030, 12'd0);
    check_val("zero_err_cleared", 64'(err), 64'd0);
    check_val("zero_done_early", 64'(done), 64'd0);
    check_val("zero_busy", 64'(busy), 64'd1);
    tick();
    check_val("zero_done", 64'(done), 64'd1);
    check_val("zero_idle", 64'(busy), 64'd0);
    tick();
    check_val("zero_done_once", 64'(done_cnt - d0), 64'd1);
    check_val("zero_nwr", 64'(wq_addr.size()), 64'd0);

    // Start during COLLECT is ignored
    clear_log();
    start_layer(12'h040, 12'd2);
    send_word(32'h00000001, 32'h0000000A);
    start_layer(12'h700, 12'd1);
    send_word(32'h00000002, 32'h0000000B);
    wait_done("ign_done", 20);
    check_val("ign_nwr", 64'(wq_addr.size()), 64'd2);
    check_write(0, 12'h040, 64'h0000000A00000001);
    check_write(1, 12'h041, 64'h0000000B00000002);

    // Reset mid-layer
    do_reset();
    clear_log();
    wr_ready = 1'b0;
    start_layer(12'h050, 12'd5);
    send_half(1'b1, 32'h0000DEAD);
    for (int i = 0; i < 3; i++) send_word(32'h300 + 32'(i), 32'h400 + 32'(i));
    check_val("mid_err_pre", 64'(err), 64'd1);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    check_val("mid_one_popped", 64'(wq_addr.size()), 64'd1);
    d0 = done_cnt;
    do_reset();
    check_val("mid_rst_valid", 64'(wr_valid), 64'd0);
    check_val("mid_rst_err", 64'(err), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    wr_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("mid_no_done", 64'(done_cnt - d0), 64'd0);
    check_val("mid_no_more_wr", 64'(wq_addr.size()), 64'd1);
    clear_log();
    start_layer(12'h060, 12'd1);
    send_word(32'hCAFEF00D, 32'h12345678);
    wait_done("mid_new_done", 20);
    check_val("mid_new_nwr", 64'(wq_addr.size()), 64'd1);
    check_write(0, 12'h060, 64'h12345678CAFEF00D);
    check_val("mid_new_err", 64'(err), 64'd0);

`ifdef BNN_PACK_STATS_EN
    // Popcount statistics
    do_reset();
    check_val("stats_rst", 64'(ones_count), 64'd0);
    start_layer(12'h070, 12'd2);
    send_word(32'hFFFFFFFF, 32'hFFFFFFFF);
    send_word(32'h00000001, 32'h00000000);
    wait_done("stats_done", 20);
    check_val("stats_ones", 64'(ones_count), 64'd65);
    tick();
    tick();
    check_val("stats_hold", 64'(ones_count), 64'd65);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_result_packer.md
Name: bnn_result_packer

Overview:
- Downstream stage of the BNN core. Captures the core's 32-bit binarised result halves, which the core presents while its store bit is high and selects with the half-select bit.
- Pairs the two halves into 64-bit output-channel words.
- Buffers the words in a small FIFO and streams them to the feature-map memory writer over a valid/ready interface with auto-incrementing addresses.
- Signals layer completion to the top-level sequencer.

Parameters:
- DEPTH, 8, FIFO depth in 64-bit words; power of two, minimum 2.
- ADDR_W, 12, width of word addresses and of the word count.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- layer_start  input  1  one-cycle pulse; latches base_addr and num_words
- base_addr  input  ADDR_W  first write address of the layer
- num_words  input  ADDR_W  number of 64-bit words expected this layer
- store_in  input  1  core store strobe; bins_in is valid while high
- half_sel  input  1  0 = bins_in is the low half [31:0]; 1 = bins_in is the high half [63:32]
- bins_in  input  32  core result bits
- wr_valid  output  1  write request to the memory writer
- wr_ready  input  1  memory writer accepts the request
- wr_addr  output  ADDR_W  write address
- wr_data  output  64  packed word {high half, low half}
- busy  output  1  high when the FSM is not in IDLE
- done  output  1  one-cycle pulse when the layer is fully written
- err  output  1  sticky protocol/overflow error; cleared only by rst or by a layer_start that is accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; FIFO is emptied; all counters and lo_valid go to 0.
  - Outputs: wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0.
  - Reset mid-operation discards all buffered words. No done pulse is produced.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - layer_start=1 latches base_addr and num_words, clears the push count, pop count, lo_valid and err.
  - Next state is COLLECT, or DRAIN if num_words=0.
  - store_in is ignored in IDLE.
- COLLECT:
  - store_in & !half_sel: low register <= bins_in; lo_valid <= 1.
    - If lo_valid was already 1, the old half is overwritten and err <= 1.
  - store_in & half_sel & lo_valid: push {bins_in, low register}; lo_valid <= 0; push count +1.
  - store_in & half_sel & !lo_valid: word dropped, err <= 1, push count unchanged.
  - Push while the FIFO is full and no pop in the same cycle: word dropped, err <= 1, push count still +1 so the layer terminates.
  - When push count reaches num_words (same edge as the last push), next state is DRAIN.
- DRAIN:
  - When the FIFO is empty and no transfer completes this cycle: done=1 for one cycle, next state IDLE.
  - store_in is ignored in DRAIN.
- layer_start while busy is ignored; it has no effect on err.
- Output port and FIFO:
  - Show-ahead: wr_valid = FIFO non-empty; wr_data = FIFO head.
  - wr_addr = latched base + pop count, wrapping modulo 2^ADDR_W.
  - A transfer completes when wr_valid & wr_ready.
  - wr_data and wr_addr must stay stable while wr_valid=1 and wr_ready=0.
  - Push and pop in the same cycle is legal at any occupancy, including full; occupancy is unchanged.
  - Latency: a high half captured at edge N appears on wr_valid at edge N+1 if the FIFO was empty.

Optional Feature:
- Macro: BNN_PACK_STATS_EN.
- Defined:
  - Adds output ones_count [15:0], the popcount of every word pushed this layer.
  - Accumulates on each push and saturates at 16'hFFFF.
  - Cleared on rst and on an accepted layer_start.
  - Held stable after done.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package bnn_pkg holds:
  - HALF_W=32 and WORD_W=64.
  - typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} pack_state_t.
- Sub-module bnn_sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports push, pop, din, dout (show-ahead), full, empty.
  - Synchronous reset.
  - Simultaneous push/pop when full is legal.

Test Plan:
- Basic layer: reset; layer_start with base=0x010, num_words=2, wr_ready=1; feed halves lo=0xAAAA5555, hi=0x0F0F0F0F, lo=0x1, hi=0x2 -> writes (0x010, 0x0F0F0F0FAAAA5555) then (0x011, 0x0000000200000001); one done pulse; busy=0; err=0.
- Backpressure/overflow: DEPTH=8, num_words=10, wr_ready=0 throughout collection -> 8 words buffered, 2 dropped, err=1. Then raise wr_ready -> exactly 8 writes at base..base+7, then done.
- Protocol error: high half without a preceding low half -> no push, err=1. Two low halves then a high half -> one word with the second low half, err=1.
- Zero-length and ignored start: num_words=0 -> done exactly 2 cycles after layer_start with no writes. A layer_start during COLLECT is ignored and base/num are unchanged.
- Reset mid-layer: rst after 3 of 5 words with 2 still queued -> wr_valid=0 next cycle, no done, err=0. A new layer then runs cleanly.
- Stats (BNN_PACK_STATS_EN): words 0xFFFFFFFFFFFFFFFF and 0x1 -> ones_count=65 at done.
